seq_addsub: RTL and testbench

Parametrised, multi-cycle adder/subtractor that processes a WIDTH-bit operand pair CHUNK bits per clock, rippling the carry between chunks through a register. It replaces the fixed 16-bit combinational ripple adder where a narrow datapath and a short critical path matter more than latency, for example a multi-cycle ALU path or an address/offset unit. A start/busy/done handshake controls it, and it produces sum, carry-out, signed-overflow and zero flags.

---
 rtl/seq_addsub_if.sv | 27 ++
 rtl/seq_addsub.sv | 109 ++++++++++
 tb/tb_seq_addsub.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_addsub_if.sv
// seq_addsub request/result bundle.
// master drives operands and start, slave returns status and flags.
interface seq_addsub_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output start, sub, cin, a, b,
    input  busy, done, sum, cout, overflow, zero
  );

  modport slave (
    input  start, sub, cin, a, b,
    output busy, done, sum, cout, overflow, zero
  );
endinterface

// File: rtl/seq_addsub.sv
// Multi-cycle add/sub: CHUNK bits per clock, carry rippled
// through a register, flags published only on completion.
module seq_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic       clk,
  input  logic       reset,
  seq_addsub_if.slave bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] CMASK =
    WIDTH'({CHUNK{1'b1}});

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, work_q, res;
  logic [IW-1:0]    idx_q;
  logic             cy_q;
  logic             last;
  logic [31:0]      sh;
  logic [CHUNK-1:0] ca, cb;
  logic [CHUNK:0]   csum;
  logic             msb_cin;
  logic             done_q, cout_q, ovf_q, zero_q;
  logic [WIDTH-1:0] sum_q;

  // Chunk slice, chunk add and merged working value.
  always_comb begin
    sh   = 32'(idx_q) * 32'(CHUNK);
    ca   = CHUNK'(a_q >> sh);
    cb   = CHUNK'(b_q >> sh);
    csum = {1'b0, ca} + {1'b0, cb}
         + (CHUNK+1)'(cy_q);
    res  = (work_q & ~(CMASK << sh))
         | (WIDTH'(csum[CHUNK-1:0]) << sh);
    // Only meaningful on the top chunk, whose MSB is bit WIDTH-1.
    msb_cin = a_q[WIDTH-1] ^ b_q[WIDTH-1]
            ^ csum[CHUNK-1];
    last = (idx_q == IW'(N-1));
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.start) state_d = RUN;
      RUN:  if (last)      state_d = IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    bus.busy     = (state_q == RUN);
    bus.done     = done_q;
    bus.sum      = sum_q;
    bus.cout     = cout_q;
    bus.overflow = ovf_q;
    bus.zero     = zero_q;
  end

  // Operand capture, chunk stepping and result publish.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      work_q <= '0;
      idx_q  <= '0;
      cy_q   <= 1'b0;
      done_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q   <= bus.a;
            b_q   <= bus.b ^ {WIDTH{bus.sub}};
            cy_q  <= bus.cin ^ bus.sub;
            idx_q <= '0;
          end
        end
        RUN: begin
          work_q <= res;
          cy_q   <= csum[CHUNK];
          idx_q  <= idx_q + 1'b1;
          if (last) begin
            sum_q  <= res;
            cout_q <= csum[CHUNK];
            ovf_q  <= msb_cin ^ csum[CHUNK];
            zero_q <= (res == '0);
            done_q <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_addsub.sv
// seq_addsub bench: directed handshake cases on 16/4 plus a
// randomized sweep of four geometries against an arithmetic model.
module tb_seq_addsub;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic        cin = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_addsub_if #(.WIDTH(16)) i16 ();
  seq_addsub_if #(.WIDTH(32)) i32 ();
  seq_addsub_if #(.WIDTH(8))  i8 ();
  seq_addsub_if #(.WIDTH(12)) i12 ();

  assign i16.start = start;
  assign i16.sub = sub;
  assign i16.cin = cin;
  assign i16.a = a[15:0];
  assign i16.b = b[15:0];
  assign i32.start = start;
  assign i32.sub = sub;
  assign i32.cin = cin;
  assign i32.a = a;
  assign i32.b = b;
  assign i8.start = start;
  assign i8.sub = sub;
  assign i8.cin = cin;
  assign i8.a = a[7:0];
  assign i8.b = b[7:0];
  assign i12.start = start;
  assign i12.sub = sub;
  assign i12.cin = cin;
  assign i12.a = a[11:0];
  assign i12.b = b[11:0];

  seq_addsub #(.WIDTH(16), .CHUNK(4)) u16 (
    .clk(clk), .reset(reset), .bus(i16));
  seq_addsub #(.WIDTH(32), .CHUNK(8)) u32 (
    .clk(clk), .reset(reset), .bus(i32));
  seq_addsub #(.WIDTH(8), .CHUNK(8)) u8 (
    .clk(clk), .reset(reset), .bus(i8));
  seq_addsub #(.WIDTH(12), .CHUNK(1)) u12 (
    .clk(clk), .reset(reset), .bus(i12));

  function automatic longint sx(
    input longint unsigned v, input int w);
    if (v[w-1]) return longint'(v) - (longint'(1) << w);
    return longint'(v);
  endfunction

  // Two's-complement reference built from plain integer arithmetic.
  task automatic model(
    input int w, input longint unsigned ra, rb,
    input logic rs, rc,
    output longint unsigned s,
    output logic co, ov, z);
    longint unsigned m, am, bm, full;
    longint sr, mx, mn;
    m  = (longint'(1) << w) - 1;
    am = ra & m;
    bm = rb & m;
    if (!rs) begin
      full = am + bm + 64'(rc);
      s    = full & m;
      co   = full[w];
      sr   = sx(am, w) + sx(bm, w) + longint'(rc);
    end else begin
      s  = (am - bm - 64'(rc)) & m;
      co = (am >= bm + 64'(rc));
      sr = sx(am, w) - sx(bm, w) - longint'(rc);
    end
    mx = (longint'(1) << (w-1)) - 1;
    mn = -(longint'(1) << (w-1));
    ov = (sr > mx) || (sr < mn);
    z  = (s == 0);
  endtask

  // Issue one op on the 16-bit unit and wait (bounded) for done.
  task automatic run16(
    input logic [15:0] ta, tb, input logic ts, tc,
    output logic [15:0] s, output logic co, ov, z,
    output int lat, output int bcnt);
    @(negedge clk);
    a = {16'h0, ta};
    b = {16'h0, tb};
    sub = ts;
    cin = tc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    bcnt = 0;
    while (!i16.done && lat < 50) begin
      bcnt += int'(i16.busy);
      @(negedge clk);
      lat++;
    end
    s  = i16.sum;
    co = i16.cout;
    ov = i16.overflow;
    z  = i16.zero;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({i16.busy, i16.done, i16.cout, i16.overflow, i16.zero}
        !== 5'b0) begin
      n_bad++;
      $display("FAIL reset flags: got %b want 00000",
        {i16.busy, i16.done, i16.cout, i16.overflow, i16.zero});
    end
    n_cmp++;
    if (i16.sum !== 16'h0) begin
      n_bad++;
      $display("FAIL reset sum: got %h want 0000", i16.sum);
    end
    reset = 1'b0;
  endtask

  task automatic test_add;
    logic [15:0] s;
    logic co, ov, z;
    int lat, bc;
    run16(16'h1234, 16'h4321, 1'b0, 1'b0, s, co, ov, z, lat, bc);
    n_cmp++;
    if (lat !== 5) begin
      n_bad++;
      $display("FAIL add latency: got %0d want 5", lat);
    end
    n_cmp++;
    if (bc !== 4) begin
      n_bad++;
      $display("FAIL add busy cycles: got %0d want 4", bc);
    end
    n_cmp++;
    if ({s, co, ov, z} !== {16'h5555, 3'b000}) begin
      n_bad++;
      $display("FAIL add result: got %h %b%b%b want 5555 000",
        s, co, ov, z);
    end
    @(negedge clk);
    n_cmp++;
    if (i16.done !== 1'b0) begin
      n_bad++;
      $display("FAIL done pulse width: got %b want 0", i16.done);
    end
  endtask

  task automatic test_wrap;
    logic [15:0] s;
    logic co, ov, z;
    int lat, bc;
    run16(16'hFFFF, 16'h0001, 1'b0, 1'b0, s, co, ov, z, lat, bc);
    n_cmp++;
    if ({s, co, ov, z} !== {16'h0000, 3'b101}) begin
      n_bad++;
      $display("FAIL wrap result: got %h %b%b%b want 0000 101",
        s, co, ov, z);
    end
  endtask

  task automatic test_sub;
    logic [15:0] s;
    logic co, ov, z;
    int lat, bc;
    run16(16'h8000, 16'h0001, 1'b1, 1'b0, s, co, ov, z, lat, bc);
    n_cmp++;
    if ({s, co, ov, z} !== {16'h7FFF, 3'b110}) begin
      n_bad++;
      $display("FAIL sub result: got %h %b%b%b want 7fff 110",
        s, co, ov, z);
    end
  endtask

  task automatic test_borrow;
    logic [15:0] s;
    logic co, ov, z;
    int lat, bc;
    run16(16'h0005, 16'h0005, 1'b1, 1'b1, s, co, ov, z, lat, bc);
    n_cmp++;
    if ({s, co, ov, z} !== {16'hFFFF, 3'b000}) begin
      n_bad++;
      $display("FAIL borrow result: got %h %b%b%b want ffff 000",
        s, co, ov, z);
    end
  endtask

  task automatic test_ignore_start;
    int lat;
    @(negedge clk);
    a = 32'h0100;
    b = 32'h0023;
    sub = 1'b0;
    cin = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 32'hFFFF;
    b = 32'hFFFF;
    sub = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 3;
    while (!i16.done && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat !== 5) begin
      n_bad++;
      $display("FAIL ignore latency: got %0d want 5", lat);
    end
    n_cmp++;
    if ({i16.sum, i16.cout} !== {16'h0123, 1'b0}) begin
      n_bad++;
      $display("FAIL ignore result: got %h %b want 0123 0",
        i16.sum, i16.cout);
    end
    @(negedge clk);
    n_cmp++;
    if (i16.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL ignore queued: busy got %b want 0", i16.busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] s;
    logic co, ov, z;
    int lat, bc;
    run16(16'h0010, 16'h0020, 1'b0, 1'b0, s, co, ov, z, lat, bc);
    a = 32'h00F0;
    b = 32'h000F;
    sub = 1'b1;
    cin = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if ({i16.busy, i16.done} !== 2'b10) begin
      n_bad++;
      $display("FAIL b2b accept: busy/done got %b%b want 10",
        i16.busy, i16.done);
    end
    lat = 1;
    while (!i16.done && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat !== 5) begin
      n_bad++;
      $display("FAIL b2b latency: got %0d want 5", lat);
    end
    n_cmp++;
    if ({i16.sum, i16.cout} !== {16'h00E1, 1'b1}) begin
      n_bad++;
      $display("FAIL b2b result: got %h %b want 00e1 1",
        i16.sum, i16.cout);
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] s;
    logic co, ov, z;
    int lat, bc, dn;
    run16(16'h00FF, 16'h0001, 1'b0, 1'b0, s, co, ov, z, lat, bc);
    @(negedge clk);
    a = 32'h1111;
    b = 32'h2222;
    sub = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({i16.busy, i16.done, i16.cout} !== 3'b000) begin
      n_bad++;
      $display("FAIL midreset flags: got %b%b%b want 000",
        i16.busy, i16.done, i16.cout);
    end
    n_cmp++;
    if (i16.sum !== 16'h0) begin
      n_bad++;
      $display("FAIL midreset sum: got %h want 0000", i16.sum);
    end
    @(negedge clk);
    reset = 1'b0;
    dn = 0;
    repeat (8) begin
      @(negedge clk);
      dn += int'(i16.done) + int'(i16.busy);
    end
    n_cmp++;
    if (dn !== 0) begin
      n_bad++;
      $display("FAIL midreset aborted: got %0d done/busy want 0", dn);
    end
  endtask

  task automatic test_random_sweep;
    int w[4] = '{16, 32, 8, 12};
    int el[4] = '{5, 5, 2, 13};
    longint unsigned gs[4];
    logic gc[4], gv[4], gz[4];
    int dc[4], gl[4];
    longint unsigned es;
    logic ec, ev, ez;
    logic [31:0] ra, rb;
    logic rs, rc;
    for (int k = 0; k < 40; k++) begin
      ra = $urandom;
      rb = (k % 8 == 3) ? ra : $urandom;
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      if (k % 8 == 5) begin
        ra = 32'hFFFFFFFF;
        rb = 32'h00000001;
      end
      for (int i = 0; i < 4; i++) begin
        dc[i] = 0;
        gl[i] = 0;
      end
      @(negedge clk);
      a = ra;
      b = rb;
      sub = rs;
      cin = rc;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 16; c++) begin
        if (i16.done) begin
          dc[0]++; gl[0] = c; gs[0] = 64'(i16.sum);
          gc[0] = i16.cout; gv[0] = i16.overflow; gz[0] = i16.zero;
        end
        if (i32.done) begin
          dc[1]++; gl[1] = c; gs[1] = 64'(i32.sum);
          gc[1] = i32.cout; gv[1] = i32.overflow; gz[1] = i32.zero;
        end
        if (i8.done) begin
          dc[2]++; gl[2] = c; gs[2] = 64'(i8.sum);
          gc[2] = i8.cout; gv[2] = i8.overflow; gz[2] = i8.zero;
        end
        if (i12.done) begin
          dc[3]++; gl[3] = c; gs[3] = 64'(i12.sum);
          gc[3] = i12.cout; gv[3] = i12.overflow; gz[3] = i12.zero;
        end
        @(negedge clk);
      end
      for (int i = 0; i < 4; i++) begin
        model(w[i], 64'(ra), 64'(rb), rs, rc, es, ec, ev, ez);
        n_cmp++;
        if (dc[i] !== 1 || gl[i] !== el[i]) begin
          n_bad++;
          $display("FAIL rnd%0d w=%0d done: got %0dx at %0d want 1x at %0d",
            k, w[i], dc[i], gl[i], el[i]);
        end else begin
          n_cmp++;
          if ({gs[i], gc[i], gv[i], gz[i]} !== {es, ec, ev, ez}) begin
            n_bad++;
            $display("FAIL rnd%0d w=%0d %s a=%h b=%h cin=%b: got %h %b%b%b want %h %b%b%b",
              k, w[i], rs ? "sub" : "add", ra, rb, rc,
              gs[i], gc[i], gv[i], gz[i], es, ec, ev, ez);
          end
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_wrap();
    test_sub();
    test_borrow();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end
endmodule
